// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read/write datapath: default geometry,
// the read-capture FSM encoding and an index-width helper.
package ddr_pkg;

  localparam int DDR_DW        = 8;  // data bits per beat
  localparam int DDR_BURST_LEN = 8;  // beats per burst (even, >= 2)
  localparam int DDR_CLW       = 4;  // width of the CAS latency field

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  // Width of a counter that must index n entries; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my_iddrx8.sv
// DDR -> SDR input register. The beat present during the clk-high phase (d0)
// is caught on the falling edge, then re-timed together with the clk-low beat
// (d1) on the rising edge, so a pair driven in cycle k is visible on q0/q1
// for the whole of cycle k+1.
module my_iddrx8 #(
  parameter int DW = ddr_pkg::DDR_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] io,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] n_q;

  // Falling-edge capture of the high-phase beat.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(negedge clk) begin
    if (rst) n_q <= '0;
    else     n_q <= io;
  end

  // Rising-edge re-timing: pair the held d0 with the low-phase d1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= n_q;
      q1 <= io;
    end
  end

endmodule

// File: rtl/ddr_rd_capture_x8.sv
// Read-burst capture: waits a programmable CAS latency after rd_cmd, gathers
// BURST_LEN/2 SDR beat pairs from the input register into a burst, then
// presents the whole burst with a single rd_valid pulse.
module ddr_rd_capture_x8
  import ddr_pkg::*;
#(
  parameter int DW        = DDR_DW,
  parameter int BURST_LEN = DDR_BURST_LEN,
  parameter int CLW       = DDR_CLW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           io,
  input  logic                    rd_cmd,
  input  logic [CLW-1:0]          cas_lat,
  output logic [DW*BURST_LEN-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    err_overlap
);

  localparam int PAIRS = BURST_LEN / 2;
  localparam int PW    = idx_w(PAIRS);
  localparam int BW    = DW * BURST_LEN;
  localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);

  rd_state_e      state;
  logic [CLW-1:0] lat_cnt;
  logic [PW-1:0]  beat_cnt;
  logic [BW-1:0]  asm_q;
  logic [BW-1:0]  asm_next;
  logic [CLW-1:0] lat_load;
  logic [DW-1:0]  q0;
  logic [DW-1:0]  q1;

  my_iddrx8 #(.DW(DW)) u_iddr (
    .clk (clk),
    .rst (rst),
    .io  (io),
    .q0  (q0),
    .q1  (q1)
  );

  // Latency preload (cas_lat of 0 behaves as 1) and in-place pair insertion.
  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lat_load = (cas_lat == '0) ? '0 : cas_lat - CLW'(1);
    asm_next = asm_q;
    asm_next[int'(beat_cnt) * 2 * DW +: 2 * DW] = {q1, q0};
  end

  // Burst FSM with latency/pair counters, assembly register and flags.
  // NOTE: the burst assembly register is reset along with the control state so
  // an aborted burst can never leak partial beats into a later rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      asm_q       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      rd_valid    <= 1'b0;
      err_overlap <= rd_cmd && (state != IDLE);
      case (state)
        IDLE: begin
          if (rd_cmd) begin
            lat_cnt <= lat_load;
            state   <= WAIT;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            beat_cnt <= '0;
            state    <= CAPT;
          end else begin
            lat_cnt <= lat_cnt - CLW'(1);
          end
        end
        CAPT: begin
          asm_q <= asm_next;
          if (beat_cnt == LAST_PAIR) begin
            rd_data  <= asm_next;
            rd_valid <= 1'b1;
            state    <= DONE;
          end else begin
            beat_cnt <= beat_cnt + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_capture_x8.sv
// Self-checking bench for ddr_rd_capture_x8. A DDR driver model puts d0 on io
// during clk-high and d1 during clk-low; accepted read commands push the
// expected burst and its rd_valid cycle to a scoreboard that is popped when
// the DUT raises rd_valid.
module tb_ddr_rd_capture_x8;
  import ddr_pkg::*;

  localparam int DW    = 8;
  localparam int BL    = 8;
  localparam int CLW   = 4;
  localparam int PAIRS = BL / 2;
  localparam int BW    = DW * BL;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  io = '0;
  logic           rd_cmd = 1'b0;
  logic [CLW-1:0] cas_lat = '0;
  logic [BW-1:0]  rd_data;
  logic           rd_valid;
  logic           busy;
  logic           err_overlap;

  ddr_rd_capture_x8 #(.DW(DW), .BURST_LEN(BL), .CLW(CLW)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io),
    .rd_cmd      (rd_cmd),
    .cas_lat     (cas_lat),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .err_overlap (err_overlap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [BW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errq[$];
  logic [15:0] drv[int];   // cycle -> {d1, d0}
  int          cyc = 0;
  int          busy_from = 1;
  int          busy_to = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs just after the edge, then drive this
  // cycle's inputs and both io beats.
  task automatic step(input logic cmd, input logic [CLW-1:0] cl, input logic r,
                      input logic [7:0] base);
    logic          exp_v;
    logic          exp_e;
    int            cle;
    logic [BW-1:0] data;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      sb.delete();
      errq.delete();
      busy_from = 1;
      busy_to   = 0;
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_rd_data", rd_data, 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_err_overlap", 64'(err_overlap), 64'(0));
    end else begin
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("rd_valid", 64'(rd_valid), 64'(exp_v));
      if (exp_v) begin
        check("rd_data", rd_data, sb[0].data);
        void'(sb.pop_front());
      end
      exp_e = (errq.size() > 0) && (errq[0] == cyc);
      if (exp_e) void'(errq.pop_front());
      check("err_overlap", 64'(err_overlap), 64'(exp_e));
      check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
    end
    rst     = r;
    rd_cmd  = cmd;
    cas_lat = cl;
    if (cmd && !r) begin
      if (cyc >= busy_from && cyc <= busy_to) begin
        errq.push_back(cyc + 1);
      end else begin
        cle       = (cl == 0) ? 1 : int'(cl);
        busy_from = cyc + 1;
        busy_to   = cyc + cle + PAIRS + 1;
        for (int i = 0; i < BL; i++) data[i*DW +: DW] = base + 8'(i);
        for (int m = 0; m < PAIRS; m++)
          drv[cyc + cle + m] = {base + 8'(2*m + 1), base + 8'(2*m)};
        sb.push_back('{cyc: cyc + cle + PAIRS + 1, data: data});
      end
    end
    io = drv.exists(cyc) ? drv[cyc][7:0] : 8'($urandom);
    @(negedge clk);
    #1;
    io = drv.exists(cyc) ? drv[cyc][15:8] : 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00);
  endtask

  a_valid_pulse: assert property (@(posedge clk) disable iff (rst) rd_valid |=> !rd_valid)
    else $error("FAIL a_valid_pulse: rd_valid high for more than one cycle");
  a_idle_busy: assert property (@(posedge clk) disable iff (rst) (dut.state == IDLE) |-> !busy)
    else $error("FAIL a_idle_busy: busy high in IDLE");

  initial begin
    // 1: reset held three cycles with io toggling
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 8'h00);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_n_q", 64'(dut.u_iddr.n_q), 64'(0));
    idle(3);

    // 2: single burst, CL=3
    step(1'b1, 4'd3, 1'b0, 8'h10);
    idle(10);

    // 3: CL=0 behaves like CL=1
    step(1'b1, 4'd0, 1'b0, 8'h20);
    idle(8);

    // 4: overlapping commands at T0+2, T0+7 and in DONE (T0+8)
    step(1'b1, 4'd3, 1'b0, 8'h30);
    idle(1);
    step(1'b1, 4'd1, 1'b0, 8'hEE);
    idle(4);
    step(1'b1, 4'd2, 1'b0, 8'hEE);
    step(1'b1, 4'd2, 1'b0, 8'hEE);
    idle(4);

    // 5: back-to-back, second command in first IDLE after DONE
    step(1'b1, 4'd2, 1'b0, 8'h40);
    idle(7);
    step(1'b1, 4'd3, 1'b0, 8'hA0);
    idle(10);

    // 6: reset in the middle of CAPT after two pairs, then a normal burst
    step(1'b1, 4'd3, 1'b0, 8'h50);
    idle(5);
    step(1'b0, '0, 1'b1, 8'h00);
    idle(3);
    step(1'b1, 4'd1, 1'b0, 8'h60);
    idle(8);

    // Maximum CAS latency, no counter wrap
    step(1'b1, 4'd15, 1'b0, 8'h70);
    idle(25);

    check("sb_drained", 64'(sb.size()), 64'(0));
    check("errq_drained", 64'(errq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
